fdiv_iter: RTL and testbench

- Sequential single-precision divider, y = x1 / x2, the inverse counterpart of the combinational multiplier in the FPU module set.
- Computes the mantissa quotient by restoring division, one quotient bit per cycle. Fixed latency.
- Number semantics match the multiplier: no denormals (exponent 0 means zero), truncation rounding, no NaN handling. Overflow saturates to infinity.
- Sits in the FPU next to fmul. Issued by the core via a start/done handshake.

---
 rtl/fdiv_iter.sv | 158 +++++++++++++++
 tb/tb_fdiv_iter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// Sequential IEEE-754 binary32 divider: restoring mantissa division, one quotient bit per cycle.
// Fixed 26-cycle latency from start acceptance to done; no denormals, truncation, saturating overflow.
module fdiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        busy,
    output logic        done,
    output logic [31:0] y,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [25:0] rem_q, rem_d;
    logic [23:0] div_q, div_d;
    logic [24:0] quo_q, quo_d;
    logic        sgn_q, sgn_d;
    logic [7:0]  e1_q, e1_d;
    logic [7:0]  e2_q, e2_d;
    logic [31:0] y_q, y_d;
    logic        ovf_q, ovf_d;
    logic        dz_q, dz_d;
    logic        done_q, done_d;

    // Datapath for one restoring step
    logic        rem_ge;
    logic [25:0] rem_diff;

    // Result formatting from the finished quotient
    logic signed [9:0] exp_s;
    logic [22:0]       mant;
    logic [31:0]       res_y;
    logic              res_ovf;
    logic              res_dz;

    always_comb begin
        rem_ge   = (rem_q >= {2'b00, div_q});
        rem_diff = rem_ge ? (rem_q - {2'b00, div_q}) : rem_q;
    end

    always_comb begin
        exp_s = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q})
              + (quo_q[24] ? 10'sd127 : 10'sd126);
        mant  = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

        res_y   = {sgn_q, exp_s[7:0], mant};
        res_ovf = 1'b0;
        res_dz  = 1'b0;
        if (e2_q == 8'd0) begin
            res_y  = {sgn_q, 8'hFF, 23'd0};
            res_dz = 1'b1;
        end else if (e1_q == 8'd0) begin
            res_y = {sgn_q, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            res_y   = {sgn_q, 8'hFF, 23'd0};
            res_ovf = 1'b1;
        end else if (exp_s <= 10'sd0) begin
            res_y = {sgn_q, 31'd0};
        end
    end

    always_comb begin
        // NOTE: every next-state value starts as a copy of its flop so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        sgn_d   = sgn_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = {3'b001, x1[22:0]};
                    div_d   = {1'b1, x2[22:0]};
                    quo_d   = '0;
                    sgn_d   = x1[31] ^ x2[31];
                    e1_d    = x1[30:23];
                    e2_d    = x2[30:23];
                    cnt_d   = 5'd24;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Remainder stays below the divisor after subtraction, so the shift never loses a set bit.
                rem_d = rem_diff << 1;
                quo_d = {quo_q[23:0], rem_ge};
                if (cnt_q == 5'd0) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            NORM: begin
                y_d     = res_y;
                ovf_d   = res_ovf;
                dz_d    = res_dz;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            sgn_q   <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            sgn_q   <= sgn_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign y    = y_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Scoreboard bench for fdiv_iter: stimulus pushes hand-computed results with their due edge,
// a negedge monitor pops and compares on every done pulse.
module tb_fdiv_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic        ovf;
    logic        dz;

    typedef struct {
        string       name;
        logic [31:0] y;
        logic        ovf;
        logic        dz;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   cyc;

    fdiv_iter dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x1   (x1),
        .x2   (x2),
        .busy (busy),
        .done (done),
        .y    (y),
        .ovf  (ovf),
        .dz   (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index of the most recent rising edge
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done at edge %0d with nothing outstanding", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_y"},   y,          e.y);
                check({e.name, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
                check({e.name, "_dz"},  {31'd0, dz},  {31'd0, e.dz});
                check({e.name, "_lat"}, cyc,        e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [31:0] ey, input logic eo,
                        input logic ed, input int accept_edge);
        exp_t e;
        e.name = name;
        e.y    = ey;
        e.ovf  = eo;
        e.dz   = ed;
        e.due  = accept_edge + 26;
        exp_q.push_back(e);
    endtask

    // One-cycle start pulse; operands are scrambled right after the capture edge.
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic eo, input logic ed);
        start = 1'b1;
        x1    = a;
        x2    = b;
        push(name, ey, eo, ed, cyc + 1);
        tick();
        start = 1'b0;
        x1    = $urandom;
        x2    = $urandom;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d results still outstanding after %0d cycles",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int c0;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        start = 1'b0;
        x1    = '0;
        x2    = '0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_y",    y,             32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        check("rst_dz",   {31'd0, dz},   32'd0);
        rst = 1'b0;
        tick();

        // 6/2, with busy counted over the whole operation
        issue("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        check("busy_cycles", busy_cnt, 32'd26);
        wait_drain("six_by_two", 40);

        issue("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0);
        wait_drain("one_by_three", 40);
        issue("neg_half", 32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0, 1'b0);
        wait_drain("neg_half", 40);
        issue("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0);
        wait_drain("overflow", 40);
        issue("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1);
        wait_drain("div_zero", 40);
        issue("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0);
        wait_drain("underflow", 40);
        issue("zero_by_zero", 32'h80000000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1);
        wait_drain("zero_by_zero", 40);

        // Back-to-back with start held: second accept on the edge after the first done
        c0    = cyc;
        start = 1'b1;
        x1    = 32'h40C00000;
        x2    = 32'h40000000;
        push("b2b_first", 32'h40400000, 1'b0, 1'b0, c0 + 1);
        push("b2b_second", 32'hBF000000, 1'b0, 1'b0, c0 + 28);
        tick();
        x1 = 32'hBF800000;
        x2 = 32'h40000000;
        while (cyc < c0 + 28) tick();
        start = 1'b0;
        x1    = 32'h3F800000;
        x2    = 32'h40400000;
        while (cyc < c0 + 40) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midcalc_busy", {31'd0, busy}, 32'd1);
        while (cyc < c0 + 45) tick();
        check("held_y", y, 32'h40400000);
        wait_drain("b2b", 60);

        // Async reset in the middle of CALC, counter at 10
        issue("abandoned", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        c0 = cyc;
        while (cyc < c0 + 14) tick();
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_y",    y,             32'd0);
        check("arst_ovf",  {31'd0, ovf},  32'd0);
        check("arst_dz",   {31'd0, dz},   32'd0);
        repeat (2) tick();
        #2;
        rst = 1'b0;
        repeat (40) tick();
        check("no_done_after_rst_y", y, 32'd0);

        issue("after_rst", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0);
        wait_drain("after_rst", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
